bru_pipe_predict: RTL and testbench
===================================

Name: bru_pipe_predict

Overview:
- Parametrised, registered successor to the combinational branch unit.
- Resolves conditional branches in the execute stage and computes the branch target.
- Compares the resolved direction against the fetch-stage prediction and produces a redirect on mispredict.
- Owns the 2-bit saturating-counter branch history table (BHT) that fetch reads for that prediction.

Parameters:
- XLEN, 32, datapath and address width.
- BHT_DEPTH, 64, number of BHT entries; must be a power of 2 and at least 2.
- BHT_IDX_W, $clog2(BHT_DEPTH), index width; derived, do not override.

Ports:
- BRP_CLOCK_50  in  1  single clock, rising edge.
- BRP_RESET_InHigh  in  1  asynchronous, active-high reset.
- BRP_lkp_pc_InBUS  in  XLEN  fetch PC for prediction lookup.
- BRP_lkp_taken  out  1  combinational prediction: MSB of BHT[lkp_pc[BHT_IDX_W+1:2]].
- BRP_valid  in  1  execute-stage branch instruction present.
- BRP_stall  in  1  pipeline stall; holds the output register.
- BRP_flush  in  1  squashes the instruction being captured this cycle.
- BRP_pc_InBUS  in  XLEN  PC of the branch.
- BRP_imm_InBUS  in  XLEN  sign-extended B-immediate.
- BRP_rs1_data_InBUS  in  XLEN  first compare operand.
- BRP_rs2_data_InBUS  in  XLEN  second compare operand.
- BRP_funct3_InBUS  in  3  branch type.
- BRP_pred_taken  in  1  prediction that travelled with the instruction.
- BRP_out_valid  out  1  registered result valid.
- BRP_taken  out  1  resolved direction.
- BRP_mispredict  out  1  resolved direction differs from pred_taken.
- BRP_redirect_pc_OutBUS  out  XLEN  correct next PC.
- BRP_misalign  out  1  taken target not 4-byte aligned.
- BRP_illegal  out  1  funct3 is 010 or 011.

Behaviour:
- Conditions (funct3): 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU. 010/011: taken=0, illegal=1, mispredict = pred_taken.
- Target = pc + imm and fallthrough = pc + 4, both modulo 2^XLEN (wrap silently).
- redirect_pc = taken ? target : fallthrough.
- misalign = taken & (target[1:0] != 0).
- Latency: one cycle. Inputs sampled on the rising edge; all out_* valid the following cycle.
- Capture rule, when stall=0:
  - out_valid <= valid & ~flush.
  - Data fields always load.
  - mispredict, misalign and illegal are gated by the captured valid, so they are 0 whenever out_valid=0.
- stall=1: every output register holds; no BHT update; inputs are ignored.
- flush and stall together: stall wins, so registers hold.
- BHT update: in any cycle with out_valid=1 and stall=0, the entry at index pc[BHT_IDX_W+1:2] of the registered instruction saturating-increments if taken, else decrements. Range 00..11.
  - Illegal instructions do not update the BHT.
- BHT state meaning: 00/01 predict not-taken, 10/11 predict taken.
- Lookup and update to the same index in the same cycle: lookup returns the pre-update value. No bypass.
- Two consecutive resolves to the same index each apply a step (00 -> 01 -> 10).
- Reset (asynchronous, at any time including mid-operation):
  - out_valid, taken, mispredict, misalign, illegal = 0; redirect_pc = 0.
  - All BHT entries = 01 (weakly not-taken).
  - Deassertion is sampled synchronously; the first capture happens on the first edge after release.
- The BHT is implemented as flops (asynchronous reset needed), not inferred RAM.

Decomposition:
- Shared package:
  - funct3 branch encodings (BEQ..BGEU).
  - BHT counter constants (SNT=00, WNT=01, WT=10, ST=11).
  - Instruction alignment constant (IALIGN_MASK=2'b11).
- One natural sub-module, bht_counter_table, holding:
  - The counter array.
  - The asynchronous reset to WNT.
  - The combinational read port.
  - The saturating update port (en, idx, taken).
- Compare logic and output pipeline register stay in the top.

Test Plan:
- Signed/unsigned compare: rs1=0xFFFFFFFF, rs2=0x00000001, one vector per funct3 -> BLT taken=1, BLTU taken=0, BGE=0, BGEU=1, BEQ=0, BNE=1, each one cycle after valid.
- Mispredict and redirect: pc=0x100, imm=0xFFFFFFF0, BEQ with equal operands, pred_taken=0 -> taken=1, mispredict=1, redirect_pc=0x0F0; repeat with pred_taken=1 -> mispredict=0.
- BHT training: after reset, lookup pc=0x40 -> 0. Resolve taken at pc=0x40 twice -> lookup=1 (counter 11). Three not-taken -> 0 (saturates at 00). Aliased pc=0x140 with BHT_DEPTH=64 reads the same entry.
- Stall/flush:
  - valid with stall=1 -> outputs unchanged, BHT unchanged.
  - valid with flush=1 -> out_valid=0, no update.
  - flush with stall=1 -> previous outputs held.
- Boundary cases:
  - pc=0xFFFFFFFC, not taken -> redirect_pc=0x00000000 (wrap).
  - imm=0x2, taken -> misalign=1.
  - funct3=010 -> illegal=1, taken=0, no BHT change.
- Asynchronous reset pulse between clock edges while out_valid=1 and counters at 11 -> outputs 0 immediately; all lookups return 0 afterwards.

Source files
------------

// File: rtl/bru_pipe_predict_pkg.sv
// Shared encodings for the pipelined branch resolve unit and its BHT.
package bru_pipe_predict_pkg;

  localparam int unsigned XLEN_DEFAULT      = 32;
  localparam int unsigned BHT_DEPTH_DEFAULT = 64;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  typedef enum logic [1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_cnt_e;

  localparam logic [1:0] IALIGN_MASK = 2'b11;

  // One saturating step of a 2-bit counter toward the resolved direction.
  function automatic logic [1:0] bht_step(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != BHT_ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != BHT_SNT) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bru_pipe_predict_if.sv
// Execute-stage branch request, registered result and fetch lookup bundle.
interface bru_pipe_predict_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] BRP_lkp_pc_InBUS;
  logic            BRP_lkp_taken;
  logic            BRP_valid;
  logic            BRP_stall;
  logic            BRP_flush;
  logic [XLEN-1:0] BRP_pc_InBUS;
  logic [XLEN-1:0] BRP_imm_InBUS;
  logic [XLEN-1:0] BRP_rs1_data_InBUS;
  logic [XLEN-1:0] BRP_rs2_data_InBUS;
  logic [2:0]      BRP_funct3_InBUS;
  logic            BRP_pred_taken;
  logic            BRP_out_valid;
  logic            BRP_taken;
  logic            BRP_mispredict;
  logic [XLEN-1:0] BRP_redirect_pc_OutBUS;
  logic            BRP_misalign;
  logic            BRP_illegal;

  modport master (
    output BRP_lkp_pc_InBUS, BRP_valid, BRP_stall, BRP_flush, BRP_pc_InBUS,
           BRP_imm_InBUS, BRP_rs1_data_InBUS, BRP_rs2_data_InBUS,
           BRP_funct3_InBUS, BRP_pred_taken,
    input  BRP_lkp_taken, BRP_out_valid, BRP_taken, BRP_mispredict,
           BRP_redirect_pc_OutBUS, BRP_misalign, BRP_illegal
  );

  modport slave (
    input  BRP_lkp_pc_InBUS, BRP_valid, BRP_stall, BRP_flush, BRP_pc_InBUS,
           BRP_imm_InBUS, BRP_rs1_data_InBUS, BRP_rs2_data_InBUS,
           BRP_funct3_InBUS, BRP_pred_taken,
    output BRP_lkp_taken, BRP_out_valid, BRP_taken, BRP_mispredict,
           BRP_redirect_pc_OutBUS, BRP_misalign, BRP_illegal
  );
endinterface

// File: rtl/bru_pipe_predict_bht_counter_table.sv
// Flop-based table of 2-bit saturating counters with one read and one update port.
module bht_counter_table
  import bru_pipe_predict_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] cnt [DEPTH];

  // Read sees the stored value; a same-cycle update lands on the next edge.
  assign rd_taken = cnt[rd_idx][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) cnt[i] <= BHT_WNT;
    end else if (upd_en) begin
      cnt[upd_idx] <= bht_step(cnt[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/bru_pipe_predict.sv
// Registered branch resolve: compare, target/redirect, mispredict detect and BHT training.
module bru_pipe_predict
  import bru_pipe_predict_pkg::*;
#(
  parameter int unsigned XLEN      = XLEN_DEFAULT,
  parameter int unsigned BHT_DEPTH = BHT_DEPTH_DEFAULT,
  parameter int unsigned BHT_IDX_W = $clog2(BHT_DEPTH)
) (
  input  logic                BRP_CLOCK_50,
  input  logic                BRP_RESET_InHigh,
  bru_pipe_predict_if.slave   bus
);

  logic clk;
  logic rst;
  assign clk = BRP_CLOCK_50;
  assign rst = BRP_RESET_InHigh;

  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] fallthrough_c;
  logic            eq_c;
  logic            lt_c;
  logic            ltu_c;
  logic            cond_c;
  logic            illegal_c;
  logic            capture_c;

  logic                 out_valid_q;
  logic                 taken_q;
  logic                 mispredict_q;
  logic [XLEN-1:0]      redirect_q;
  logic                 misalign_q;
  logic                 illegal_q;
  logic [BHT_IDX_W-1:0] idx_q;

  assign target_c      = bus.BRP_pc_InBUS + bus.BRP_imm_InBUS;
  assign fallthrough_c = bus.BRP_pc_InBUS + XLEN'(4);
  assign eq_c          = (bus.BRP_rs1_data_InBUS == bus.BRP_rs2_data_InBUS);
  assign lt_c          = ($signed(bus.BRP_rs1_data_InBUS) < $signed(bus.BRP_rs2_data_InBUS));
  assign ltu_c         = (bus.BRP_rs1_data_InBUS < bus.BRP_rs2_data_InBUS);
  assign capture_c     = bus.BRP_valid & ~bus.BRP_flush;

  // Reserved funct3 encodings resolve not-taken and are flagged illegal.
  always_comb begin
    cond_c    = 1'b0;
    illegal_c = 1'b0;
    case (bus.BRP_funct3_InBUS)
      F3_BEQ:  cond_c = eq_c;
      F3_BNE:  cond_c = ~eq_c;
      F3_BLT:  cond_c = lt_c;
      F3_BGE:  cond_c = ~lt_c;
      F3_BLTU: cond_c = ltu_c;
      F3_BGEU: cond_c = ~ltu_c;
      default: illegal_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      misalign_q   <= 1'b0;
      illegal_q    <= 1'b0;
      idx_q        <= '0;
    end else if (!bus.BRP_stall) begin
      out_valid_q  <= capture_c;
      taken_q      <= cond_c;
      redirect_q   <= cond_c ? target_c : fallthrough_c;
      idx_q        <= bus.BRP_pc_InBUS[BHT_IDX_W+1:2];
      mispredict_q <= capture_c & (cond_c ^ bus.BRP_pred_taken);
      misalign_q   <= capture_c & cond_c & ((target_c[1:0] & IALIGN_MASK) != 2'b00);
      illegal_q    <= capture_c & illegal_c;
    end
  end

  // Training follows the registered instruction, so a stalled result trains once it drains.
  bht_counter_table #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (bus.BRP_lkp_pc_InBUS[BHT_IDX_W+1:2]),
    .rd_taken  (bus.BRP_lkp_taken),
    .upd_en    (out_valid_q & ~bus.BRP_stall & ~illegal_q),
    .upd_idx   (idx_q),
    .upd_taken (taken_q)
  );

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.BRP_pc_InBUS[XLEN-1:BHT_IDX_W+2], bus.BRP_pc_InBUS[1:0],
                            bus.BRP_lkp_pc_InBUS[XLEN-1:BHT_IDX_W+2], bus.BRP_lkp_pc_InBUS[1:0]};

  assign bus.BRP_out_valid          = out_valid_q;
  assign bus.BRP_taken              = taken_q;
  assign bus.BRP_mispredict         = mispredict_q;
  assign bus.BRP_redirect_pc_OutBUS = redirect_q;
  assign bus.BRP_misalign           = misalign_q;
  assign bus.BRP_illegal            = illegal_q;

endmodule

// File: tb/tb_bru_pipe_predict.sv
// Directed bench for bru_pipe_predict: compare table, BHT training, stall/flush, async reset.
module tb_bru_pipe_predict;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bru_pipe_predict_if #(.XLEN(32)) bus ();

  bru_pipe_predict #(.XLEN(32), .BHT_DEPTH(64)) dut (
    .BRP_CLOCK_50     (clk),
    .BRP_RESET_InHigh (rst),
    .bus              (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  f3;
    logic        pred;
    logic        e_taken;
    logic        e_mis;
    logic [31:0] e_redir;
    logic        e_misal;
    logic        e_ill;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic pred,
                        input logic v, input logic st, input logic fl);
    bus.BRP_pc_InBUS       = pc;
    bus.BRP_imm_InBUS      = imm;
    bus.BRP_funct3_InBUS   = f3;
    bus.BRP_rs1_data_InBUS = rs1;
    bus.BRP_rs2_data_InBUS = rs2;
    bus.BRP_pred_taken     = pred;
    bus.BRP_valid          = v;
    bus.BRP_stall          = st;
    bus.BRP_flush          = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.BRP_valid = 1'b0;
    bus.BRP_stall = 1'b0;
    bus.BRP_flush = 1'b0;
  endtask

  task automatic lk(input string name, input logic [31:0] pc, input logic exp);
    bus.BRP_lkp_pc_InBUS = pc;
    #1;
    chk(name, 32'(bus.BRP_lkp_taken), 32'(exp));
  endtask

  // n back-to-back resolves at pc (BEQ equal = taken, BNE equal = not taken), then one drain edge.
  task automatic resolve_n(input logic [31:0] pc, input logic tk, input int n);
    for (int i = 0; i < n; i++) begin
      set_in(pc, 32'h10, tk ? 3'b000 : 3'b001, 32'd5, 32'd5, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    idle();
    tick();
  endtask

  task automatic chk_out(input string tag, input logic v, input logic tk, input logic mis,
                         input logic [31:0] redir, input logic mal, input logic ill);
    chk({tag, ".out_valid"},  32'(bus.BRP_out_valid),  32'(v));
    chk({tag, ".taken"},      32'(bus.BRP_taken),      32'(tk));
    chk({tag, ".mispredict"}, 32'(bus.BRP_mispredict), 32'(mis));
    chk({tag, ".redirect"},   bus.BRP_redirect_pc_OutBUS, redir);
    chk({tag, ".misalign"},   32'(bus.BRP_misalign),   32'(mal));
    chk({tag, ".illegal"},    32'(bus.BRP_illegal),    32'(ill));
  endtask

  initial begin
    // signed/unsigned compare with rs1=-1, rs2=1, pc=0x200, imm=8, pred=0
    vecs[0]  = '{32'h200, 32'h8, 32'hFFFFFFFF, 32'h1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h204, 1'b0, 1'b0};
    vecs[1]  = '{32'h200, 32'h8, 32'hFFFFFFFF, 32'h1, 3'b001, 1'b0, 1'b1, 1'b1, 32'h208, 1'b0, 1'b0};
    vecs[2]  = '{32'h200, 32'h8, 32'hFFFFFFFF, 32'h1, 3'b100, 1'b0, 1'b1, 1'b1, 32'h208, 1'b0, 1'b0};
    vecs[3]  = '{32'h200, 32'h8, 32'hFFFFFFFF, 32'h1, 3'b101, 1'b0, 1'b0, 1'b0, 32'h204, 1'b0, 1'b0};
    vecs[4]  = '{32'h200, 32'h8, 32'hFFFFFFFF, 32'h1, 3'b110, 1'b0, 1'b0, 1'b0, 32'h204, 1'b0, 1'b0};
    vecs[5]  = '{32'h200, 32'h8, 32'hFFFFFFFF, 32'h1, 3'b111, 1'b0, 1'b1, 1'b1, 32'h208, 1'b0, 1'b0};
    // backward branch mispredict / correct predict
    vecs[6]  = '{32'h100, 32'hFFFFFFF0, 32'd5, 32'd5, 3'b000, 1'b0, 1'b1, 1'b1, 32'h0F0, 1'b0, 1'b0};
    vecs[7]  = '{32'h100, 32'hFFFFFFF0, 32'd5, 32'd5, 3'b000, 1'b1, 1'b1, 1'b0, 32'h0F0, 1'b0, 1'b0};
    // fallthrough wrap, misaligned target taken / not taken
    vecs[8]  = '{32'hFFFFFFFC, 32'h8, 32'd5, 32'd5, 3'b001, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[9]  = '{32'h300, 32'h2, 32'd5, 32'd5, 3'b000, 1'b1, 1'b1, 1'b0, 32'h302, 1'b1, 1'b0};
    vecs[10] = '{32'h300, 32'h2, 32'd5, 32'd5, 3'b001, 1'b0, 1'b0, 1'b0, 32'h304, 1'b0, 1'b0};

    set_in(32'h0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.BRP_lkp_pc_InBUS = 32'h0;
    #12;
    chk_out("reset", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    lk("reset.lkp40", 32'h40, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].pc, vecs[i].imm, vecs[i].f3, vecs[i].rs1, vecs[i].rs2, vecs[i].pred,
             1'b1, 1'b0, 1'b0);
      tick();
      chk_out($sformatf("vec%0d", i), 1'b1, vecs[i].e_taken, vecs[i].e_mis, vecs[i].e_redir,
              vecs[i].e_misal, vecs[i].e_ill);
    end
    idle();
    tick();

    // fresh table for training
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    lk("train.init", 32'h40, 1'b0);
    resolve_n(32'h40, 1'b1, 2);
    lk("train.st",      32'h40,  1'b1);
    lk("train.alias",   32'h140, 1'b1);
    lk("train.other",   32'h44,  1'b0);
    resolve_n(32'h40, 1'b0, 1);
    lk("train.wt", 32'h40, 1'b1);
    resolve_n(32'h40, 1'b0, 1);
    lk("train.wnt", 32'h40, 1'b0);
    resolve_n(32'h40, 1'b0, 2);
    lk("train.snt", 32'h40, 1'b0);
    resolve_n(32'h40, 1'b1, 2);
    lk("train.sat_lo", 32'h40, 1'b1);

    // stall holds outputs and defers training of the registered branch
    set_in(32'h80, 32'h10, 3'b000, 32'd5, 32'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("stall.pre", 1'b1, 1'b1, 1'b1, 32'h90, 1'b0, 1'b0);
    set_in(32'h84, 32'h20, 3'b001, 32'd5, 32'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("stall.hold", 1'b1, 1'b1, 1'b1, 32'h90, 1'b0, 1'b0);
    lk("stall.noupd", 32'h80, 1'b0);
    set_in(32'h88, 32'h20, 3'b001, 32'd5, 32'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    chk_out("stallflush.hold", 1'b1, 1'b1, 1'b1, 32'h90, 1'b0, 1'b0);
    idle();
    tick();
    chk("drain.out_valid",  32'(bus.BRP_out_valid),  32'h0);
    chk("drain.mispredict", 32'(bus.BRP_mispredict), 32'h0);
    lk("drain.upd", 32'h80, 1'b1);

    // flushed not-taken branch must neither report nor train
    set_in(32'h80, 32'h10, 3'b001, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("flush.out_valid",  32'(bus.BRP_out_valid),  32'h0);
    chk("flush.mispredict", 32'(bus.BRP_mispredict), 32'h0);
    idle();
    tick();
    lk("flush.noupd", 32'h80, 1'b1);

    // illegal funct3 must not pull a taken-leaning counter down
    resolve_n(32'hC0, 1'b1, 1);
    lk("ill.pre", 32'hC0, 1'b1);
    set_in(32'hC0, 32'h10, 3'b010, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("ill", 1'b1, 1'b0, 1'b1, 32'hC4, 1'b0, 1'b1);
    set_in(32'hC0, 32'h10, 3'b011, 32'd5, 32'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("ill011", 1'b1, 1'b0, 1'b0, 32'hC4, 1'b0, 1'b1);
    idle();
    tick();
    chk("ill.clear", 32'(bus.BRP_illegal), 32'h0);
    lk("ill.noupd", 32'hC0, 1'b1);

    // async reset mid-operation with out_valid=1 and counter 0x40 at 11
    set_in(32'h40, 32'h10, 3'b000, 32'd5, 32'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk("arst.pre_valid", 32'(bus.BRP_out_valid), 32'h1);
    idle();
    #2 rst = 1'b1;
    #1;
    chk_out("arst", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    lk("arst.lkp40", 32'h40, 1'b0);
    lk("arst.lkp80", 32'h80, 1'b0);
    lk("arst.lkpC0", 32'hC0, 1'b0);
    rst = 1'b0;
    tick();
    chk("arst.post_valid", 32'(bus.BRP_out_valid), 32'h0);
    lk("arst.post40", 32'h40, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
